// File: rtl/cm0ik_stim_launch_pkg.sv
// Shared definitions for the stimulus launcher.
//   stim_state_e : launcher FSM encoding (IDLE = 1'b0, HOLD = 1'b1)
//   is_pow2()    : FIFO depth legality check, evaluated at elaboration
package cm0ik_stim_launch_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } stim_state_e;

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/cm0ik_stim_fifo.sv
// Synchronous FIFO that buffers {hold, word} entries for the launcher.
// Ports:
//   HCLK, HRESET            clock, async active-high reset (flushes pointers)
//   push_valid/push_ready   producer handshake; push_ready = !full
//   push_data               entry written on an accepted push
//   pop                     consume the head entry (ignored when empty)
//   pop_data                head entry, valid whenever !empty
//   full, empty             occupancy flags
module cm0ik_stim_fifo
  import cm0ik_stim_launch_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("cm0ik_stim_fifo: DEPTH must be a power of 2 and >= 2");
  end

  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push_fire;
  logic             pop_fire;

  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty      = (wr_ptr == rd_ptr);
  // Readiness depends on occupancy only, so a same-cycle pop never frees a full FIFO.
  assign push_ready = !full;
  assign push_fire  = push_valid && !full;
  assign pop_fire   = pop && !empty;
  assign pop_data   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + 1'b1;
      if (pop_fire)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (push_fire) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/cm0ik_stim_launch.sv
// Stimulus launcher feeding the netlist input-delay stage. Words arrive with a
// per-word hold count, are buffered in a FIFO and driven on a registered bus
// for that many cycles each, back to back when the FIFO has the next word.
// HRESET asserts asynchronously; its release is expected to be synchronised
// to HCLK by the upstream reset generator.
// Ports:
//   HCLK, HRESET   clock, async active-high reset
//   stim_valid/stim_ready/stim_data/stim_hold   stimulus input handshake
//   launch_en      run/pause; low freezes counter and state
//   dataout        registered stimulus bus
//   launch         pulse in the first cycle a word is on dataout
//   busy           high in HOLD
//   underrun       pulse when a hold expires with nothing queued
//
// state | meaning
// IDLE  | nothing being held; dataout keeps the last word (or RESETVAL)
// HOLD  | current word on dataout, cnt = cycles remaining including this one
module cm0ik_stim_launch
  import cm0ik_stim_launch_pkg::*;
#(
  parameter int                BUSWIDTH = 1,
  parameter int                DEPTH    = 4,
  parameter int                HOLDW    = 8,
  parameter logic [BUSWIDTH-1:0] RESETVAL = '0
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic                stim_valid,
  output logic                stim_ready,
  input  logic [BUSWIDTH-1:0] stim_data,
  input  logic [HOLDW-1:0]    stim_hold,
  input  logic                launch_en,
  output logic [BUSWIDTH-1:0] dataout,
  output logic                launch,
  output logic                busy,
  output logic                underrun
);

  localparam int EW = BUSWIDTH + HOLDW;

  stim_state_e         state_q, state_d;
  logic [HOLDW-1:0]    cnt_q, cnt_d;
  logic [BUSWIDTH-1:0] data_d;
  logic                launch_d;
  logic                underrun_d;
  logic                pop;
  logic                empty;
  logic                full;
  logic [EW-1:0]       head;
  logic [HOLDW-1:0]    head_hold;
  logic [BUSWIDTH-1:0] head_data;
  logic [HOLDW-1:0]    head_cnt;

  cm0ik_stim_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .push_valid (stim_valid),
    .push_ready (stim_ready),
    .push_data  ({stim_hold, stim_data}),
    .pop        (pop),
    .pop_data   (head),
    .full       (full),
    .empty      (empty)
  );

  assign head_hold = head[EW-1:BUSWIDTH];
  assign head_data = head[BUSWIDTH-1:0];
  // A zero hold still shows the word for one cycle.
  assign head_cnt  = (head_hold == '0) ? HOLDW'(1) : head_hold;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_d     = dataout;
    launch_d   = 1'b0;
    underrun_d = 1'b0;
    pop        = 1'b0;
    if (launch_en) begin
      unique case (state_q)
        IDLE: begin
          if (!empty) begin
            pop      = 1'b1;
            data_d   = head_data;
            cnt_d    = head_cnt;
            launch_d = 1'b1;
            state_d  = HOLD;
          end
        end
        HOLD: begin
          if (cnt_q > HOLDW'(1)) begin
            cnt_d = cnt_q - 1'b1;
          end else if (!empty) begin
            pop      = 1'b1;
            data_d   = head_data;
            cnt_d    = head_cnt;
            launch_d = 1'b1;
          end else begin
            cnt_d      = '0;
            underrun_d = 1'b1;
            state_d    = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dataout  <= RESETVAL;
      launch   <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dataout  <= data_d;
      launch   <= launch_d;
      underrun <= underrun_d;
    end
  end

  assign busy = (state_q == HOLD);

  // full is only needed inside the FIFO for stim_ready; kept visible for debug.
  logic unused_full;
  assign unused_full = full;

endmodule
